// File: rtl/sample_mem_arbiter.sv
// Purpose : shares one single-port sample RAM between the capture write stream and host readout, as a circular buffer.
// Latency : read issue to rd_valid = 2 cycles (RAM read + output buffer capture); writes land in RAM the cycle they arrive.
// Backpr. : writes are never stalled (dropped + sticky overflow when full); page_full warns HEADROOM words early; readout is valid/ready.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   flush                clears pointers, occupancy, overflow, in-flight read and output buffer
//   wr_en, wr_data       capture packet stream (no stall)
//   page_full, overflow  back-pressure to capture core; sticky drop flag
//   rd_valid, rd_ready,  readout stream, rd_data registered and held while stalled
//   rd_data
//   occupancy            words in RAM not yet fetched (0..DEPTH)
//   mem_*                single-port RAM interface; mem_rdata valid 1 cycle after a read issue
//   drop_count           only when SMA_DROP_COUNT_EN is defined: saturating dropped-write counter
//
// Optional feature macro: SMA_DROP_COUNT_EN

module sample_mem_arbiter #(
    parameter int PACKET_WIDTH = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int HEADROOM     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [PACKET_WIDTH-1:0] wr_data,
    output logic                    page_full,
    output logic                    overflow,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [PACKET_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]     occupancy,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [PACKET_WIDTH-1:0] mem_wdata,
    input  logic [PACKET_WIDTH-1:0] mem_rdata
`ifdef SMA_DROP_COUNT_EN
    ,
    output logic [15:0]             drop_count
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_OCC  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH - HEADROOM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  stateNext;

    logic [ADDR_WIDTH-1:0]   wrPtr;
    logic [ADDR_WIDTH-1:0]   rdPtr;
    logic [ADDR_WIDTH:0]     occNext;
    logic                    readInFlight;
    logic [1:0]              bufCount;
    logic [PACKET_WIDTH-1:0] bufHead;
    logic [PACKET_WIDTH-1:0] bufTail;

    logic                    clear;
    logic                    bufferFull;
    logic                    wrAccept;
    logic                    wrDrop;
    logic                    rdIssue;
    logic                    popWord;
    logic [1:0]              slotsUsed;

    assign clear      = reset | flush;
    assign bufferFull = (occupancy == DEPTH_OCC);
    assign wrAccept   = !clear && wr_en && !bufferFull;
    assign wrDrop     = !clear && wr_en && bufferFull;
    assign popWord    = rd_valid && rd_ready;

    // Output-buffer slots that will be committed once this cycle's pop is
    // taken into account. Counting the pop lets a read issue every cycle
    // while the consumer keeps up, yet never lets more than two words be
    // owed to the 2-entry buffer.
    assign slotsUsed  = bufCount + {1'b0, readInFlight} - {1'b0, popWord};

    // The write stream always owns the RAM port; reads only fill idle cycles.
    assign rdIssue    = !clear && !wr_en && (occupancy != '0) && (slotsUsed < 2'd2);

    assign mem_en     = wrAccept || rdIssue;
    assign mem_we     = wrAccept;
    assign mem_addr   = wrAccept ? wrPtr : rdPtr;
    assign mem_wdata  = wr_data;

    assign rd_valid   = (bufCount != 2'd0);
    assign rd_data    = bufHead;

    always_comb begin
        occNext = occupancy;
        if (wrAccept) begin
            occNext = occupancy + 1'b1;
        end else if (rdIssue) begin
            occNext = occupancy - 1'b1;
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (clear) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
            page_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdIssue) begin
                rdPtr <= rdPtr + 1'b1;
            end
            occupancy <= occNext;
            page_full <= (occNext >= FULL_LEVEL);
            if (wrDrop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SMA_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            drop_count <= '0;
        end else if (wrDrop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

    // Output buffer occupancy and read-in-flight tracking. The RAM word for
    // a read issued last cycle is on mem_rdata now and is always pushed.
    always_ff @(posedge clk) begin
        if (clear) begin
            readInFlight <= 1'b0;
            bufCount     <= 2'd0;
        end else begin
            readInFlight <= rdIssue;
            case ({readInFlight, popWord})
                2'b10:   bufCount <= bufCount + 1'b1;
                2'b01:   bufCount <= bufCount - 1'b1;
                default: bufCount <= bufCount;
            endcase
        end
    end

    // Output buffer data; head is what rd_data shows and only moves on a pop
    // or on a push into an empty (or emptying) buffer.
    always_ff @(posedge clk) begin
        case ({readInFlight, popWord})
            2'b10: begin
                if (bufCount == 2'd0) begin
                    bufHead <= mem_rdata;
                end else begin
                    bufTail <= mem_rdata;
                end
            end
            2'b01: begin
                bufHead <= bufTail;
            end
            2'b11: begin
                if (bufCount == 2'd1) begin
                    bufHead <= mem_rdata;
                end else begin
                    bufHead <= bufTail;
                    bufTail <= mem_rdata;
                end
            end
            default: begin
                bufHead <= bufHead;
            end
        endcase
    end

    // Buffer lifecycle tracking.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (wrAccept) begin
                    stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!wrAccept && (occNext == '0)) begin
                    stateNext = (rd_valid || readInFlight || rdIssue) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (wrAccept) begin
                    stateNext = ACTIVE;
                end else if (!rd_valid && !readInFlight) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
